// File: rtl/mux_fwd_pipe_pkg.sv
// Shared constants for the forwarding mux: RF source code, zero register, stat counter width.
package mux_fwd_pipe_pkg;

   localparam int ZERO_REG = 0;
   localparam int STAT_W   = 16;

   // The register file is always the code one past the last forwarding source.
   function automatic int rf_code(input int num_fwd);
      return num_fwd;
   endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Combinational priority match across forwarding sources; lowest index wins, register file is the fallback.
module fwd_prio_sel
   import mux_fwd_pipe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_FWD = 3,
   parameter int ADDR_W  = 5,
   parameter int SRC_W   = $clog2(NUM_FWD+1)
) (
   input  logic [ADDR_W-1:0]         rd_addr,
   input  logic [WIDTH-1:0]          rf_data,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD-1:0]        fwd_rdy,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
   input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
   output logic [SRC_W-1:0]          win_code,
   output logic [WIDTH-1:0]          win_data,
   output logic                      win_rdy,
   output logic                      win_fwd
);

   logic               rd_zero;
   logic [NUM_FWD-1:0] match;

   assign rd_zero = (rd_addr == ADDR_W'(ZERO_REG));

   for (genvar g = 0; g < NUM_FWD; g++) begin : g_match
      assign match[g] = fwd_we[g] && (fwd_addr[g*ADDR_W +: ADDR_W] == rd_addr) && !rd_zero;
   end

   // Scan from lowest priority upward so the nearest matching stage overwrites the rest.
   always_comb begin
      win_code = SRC_W'(rf_code(NUM_FWD));
      win_data = rf_data;
      win_rdy  = 1'b1;
      win_fwd  = 1'b0;
      for (int i = NUM_FWD-1; i >= 0; i--) begin
         if (match[i]) begin
            win_code = SRC_W'(i);
            win_data = fwd_data[i*WIDTH +: WIDTH];
            win_rdy  = fwd_rdy[i];
            win_fwd  = 1'b1;
         end
      end
      if (rd_zero) win_data = '0;
   end

endmodule

// File: rtl/mux_fwd_pipe.sv
// Registered priority forwarding mux with hazard stall; stat counters enabled by MUX_FWD_STAT_EN.
module mux_fwd_pipe
   import mux_fwd_pipe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_FWD = 3,
   parameter int ADDR_W  = 5,
   localparam int SRC_W  = $clog2(NUM_FWD+1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic [ADDR_W-1:0]             rd_addr,
   input  logic [WIDTH-1:0]              rf_data,
   input  logic [NUM_FWD-1:0]            fwd_we,
   input  logic [NUM_FWD-1:0]            fwd_rdy,
   input  logic [NUM_FWD*ADDR_W-1:0]     fwd_addr,
   input  logic [NUM_FWD*WIDTH-1:0]      fwd_data,
   output logic                          hazard_stall,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   output logic [SRC_W-1:0]              q_src,
   output logic [(NUM_FWD+1)*STAT_W-1:0] stat_bus
);

   logic [SRC_W-1:0] win_code;
   logic [WIDTH-1:0] win_data;
   logic             win_rdy, win_fwd, load_en;
   logic [WIDTH-1:0] q_q, q_d;
   logic             vld_q, vld_d;
   logic [SRC_W-1:0] src_q, src_d;

   fwd_prio_sel #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SRC_W(SRC_W)) u_sel (
      .rd_addr  (rd_addr),
      .rf_data  (rf_data),
      .fwd_we   (fwd_we),
      .fwd_rdy  (fwd_rdy),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .win_code (win_code),
      .win_data (win_data),
      .win_rdy  (win_rdy),
      .win_fwd  (win_fwd)
   );

   assign hazard_stall = in_valid && win_fwd && !win_rdy;
   assign load_en      = !flush && !stall && !hazard_stall;

   always_comb begin
      q_d   = q_q;
      vld_d = vld_q;
      src_d = src_q;
      if (flush) begin
         q_d   = '0;
         vld_d = 1'b0;
         src_d = SRC_W'(rf_code(NUM_FWD));
      end else if (load_en) begin
         q_d   = win_data;
         vld_d = in_valid;
         src_d = win_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= '0;
         vld_q <= 1'b0;
         src_q <= SRC_W'(rf_code(NUM_FWD));
      end else begin
         q_q   <= q_d;
         vld_q <= vld_d;
         src_q <= src_d;
      end
   end

   assign q       = q_q;
   assign q_valid = vld_q;
   assign q_src   = src_q;

`ifdef MUX_FWD_STAT_EN
   for (genvar g = 0; g <= NUM_FWD; g++) begin : g_stat
      logic [STAT_W-1:0] cnt_q, cnt_d;
      // Saturate rather than wrap so a long run never reads back as a small count.
      always_comb begin
         cnt_d = cnt_q;
         if (load_en && in_valid && (win_code == SRC_W'(g)) && (cnt_q != '1))
            cnt_d = cnt_q + STAT_W'(1);
      end
      always_ff @(posedge clk) begin
         if (reset) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end
      assign stat_bus[g*STAT_W +: STAT_W] = cnt_q;
   end
`else
   assign stat_bus = '0;
`endif

endmodule

// File: tb/tb_mux_fwd_pipe.sv
// Directed bench for mux_fwd_pipe; stat saturation run only when MUX_FWD_STAT_EN is defined.
module tb_mux_fwd_pipe;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid;
   logic [4:0]  rd_addr;
   logic [31:0] rf_data;
   logic [2:0]  fwd_we, fwd_rdy;
   logic [14:0] fwd_addr;
   logic [95:0] fwd_data;
   logic        hazard_stall;
   logic [31:0] q;
   logic        q_valid;
   logic [1:0]  q_src;
   logic [63:0] stat_bus;

   int total = 0;
   int passed = 0;

   mux_fwd_pipe dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .rd_addr(rd_addr), .rf_data(rf_data), .fwd_we(fwd_we), .fwd_rdy(fwd_rdy),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .hazard_stall(hazard_stall),
      .q(q), .q_valid(q_valid), .q_src(q_src), .stat_bus(stat_bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
      rd_addr = 5'($urandom); rf_data = $urandom;
      fwd_we = 3'b111; fwd_rdy = 3'($urandom);
      fwd_addr = {3{rd_addr}}; fwd_data = {$urandom, $urandom, $urandom};
      step();
      rf_data = $urandom; stall = 1'b1;
      step();
      chk("rst_q", 64'(q), 64'h0);
      chk("rst_qv", 64'(q_valid), 64'h0);
      chk("rst_src", 64'(q_src), 64'd3);
      chk("rst_stat", stat_bus, 64'h0);

      // Register-file fallback
      reset = 1'b0; stall = 1'b0; in_valid = 1'b1;
      rd_addr = 5'd8; rf_data = 32'h1234; fwd_we = 3'b000; fwd_rdy = 3'b111;
      fwd_addr = {5'd8, 5'd8, 5'd8};
      fwd_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
      #1 chk("rf_haz", 64'(hazard_stall), 64'h0);
      step();
      chk("rf_q", 64'(q), 64'h1234);
      chk("rf_src", 64'(q_src), 64'd3);
      chk("rf_qv", 64'(q_valid), 64'h1);

      // Sources 0 and 2 both match; nearest wins
      fwd_we = 3'b101;
      step();
      chk("prio_q", 64'(q), 64'hAAAA);
      chk("prio_src", 64'(q_src), 64'd0);

      // Source 0 unready masks ready source 1
      fwd_we = 3'b011; fwd_rdy = 3'b010;
      fwd_data = {32'hCCCC, 32'hBBBB, 32'hA0A0};
      #1 chk("haz_on", 64'(hazard_stall), 64'h1);
      step();
      chk("haz_hold_q", 64'(q), 64'hAAAA);
      fwd_rdy = 3'b011;
      #1 chk("haz_off", 64'(hazard_stall), 64'h0);
      step();
      chk("haz_load_q", 64'(q), 64'hA0A0);
      chk("haz_load_src", 64'(q_src), 64'd0);

      // Stall holds, flush beats stall
      fwd_we = 3'b000; rf_data = 32'h55;
      step();
      chk("pre_q", 64'(q), 64'h55);
      stall = 1'b1; rf_data = 32'h77;
      step();
      chk("stall_q", 64'(q), 64'h55);
      flush = 1'b1;
      step();
      chk("flush_q", 64'(q), 64'h0);
      chk("flush_qv", 64'(q_valid), 64'h0);
      chk("flush_src", 64'(q_src), 64'd3);
      stall = 1'b0; flush = 1'b0;

      // r0 always reads zero and never forwards
      rd_addr = 5'd0; rf_data = 32'h9999; fwd_we = 3'b001; fwd_rdy = 3'b000;
      fwd_addr = {5'd8, 5'd8, 5'd0}; fwd_data = {32'hCCCC, 32'hBBBB, 32'hFFFF};
      #1 chk("r0_haz", 64'(hazard_stall), 64'h0);
      step();
      chk("r0_q", 64'(q), 64'h0);
      chk("r0_src", 64'(q_src), 64'd3);
      chk("r0_qv", 64'(q_valid), 64'h1);

      // in_valid=0 suppresses hazard and still loads
      rd_addr = 5'd8; fwd_addr = {5'd8, 5'd8, 5'd8}; in_valid = 1'b0;
      #1 chk("inv_haz", 64'(hazard_stall), 64'h0);
      step();
      chk("inv_qv", 64'(q_valid), 64'h0);
      chk("inv_src", 64'(q_src), 64'd0);
      chk("inv_q", 64'(q), 64'hFFFF);

      // Reset during an active hazard
      in_valid = 1'b1;
      #1 chk("rstmid_haz", 64'(hazard_stall), 64'h1);
      reset = 1'b1;
      step();
      chk("rstmid_q", 64'(q), 64'h0);
      chk("rstmid_src", 64'(q_src), 64'd3);
      chk("rstmid_stat", stat_bus, 64'h0);
      reset = 1'b0;

      // Long run of source-1 wins
      fwd_we = 3'b010; fwd_rdy = 3'b111;
`ifdef MUX_FWD_STAT_EN
      for (int i = 0; i < 70000; i++) @(posedge clk);
      #1;
      chk("stat_sat1", 64'(stat_bus[31:16]), 64'hFFFF);
      chk("stat_others", {stat_bus[63:32], 16'h0, stat_bus[15:0]}, 64'h0);
`else
      for (int i = 0; i < 20; i++) @(posedge clk);
      #1;
      chk("stat_tied", stat_bus, 64'h0);
`endif
      chk("run_src", 64'(q_src), 64'd1);
      chk("run_q", 64'(q), 64'hBBBB);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
